cpu_controller: RTL

Eight-phase instruction sequencer for the 8-bit accumulator CPU. It issues the control strobes that drive the memory, instruction register, program counter, accumulator and ALU. It also consumes the 3-bit opcode from the instruction register and the ALU's `a_is_zero` flag. It is the control-side counterpart of the ALU: the ALU executes the opcode, and this block decides when each operation happens and what is done with the result.

---
 rtl/cpu_controller_pkg.sv | 42 ++++
 rtl/cpu_controller_if.sv | 28 ++
 rtl/cpu_controller_phase_counter.sv | 22 ++
 rtl/cpu_controller.sv | 111 +++++++++++
 4 files changed

// File: rtl/cpu_controller_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, sequencer phases,
// the control-strobe bundle and the ALU-operation decode.
package cpu_pkg;

   localparam logic [2:0] OP_HLT = 3'b000;
   localparam logic [2:0] OP_SKZ = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDA = 3'b101;
   localparam logic [2:0] OP_STO = 3'b110;
   localparam logic [2:0] OP_JMP = 3'b111;

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_e;

   typedef struct packed {
      logic sel;
      logic rd;
      logic ld_ir;
      logic inc_pc;
      logic ld_pc;
      logic ld_ac;
      logic wr;
      logic data_e;
      logic halt;
   } strobe_t;

   // Opcodes whose result is loaded into the accumulator from the ALU.
   function automatic logic is_aluop(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
   endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Controller-to-datapath bundle: sequencing inputs, control strobes and debug phase.
interface cpu_controller_if;

   logic       en;
   logic [2:0] opcode;
   logic       zero;
   logic       sel;
   logic       rd;
   logic       ld_ir;
   logic       inc_pc;
   logic       ld_pc;
   logic       ld_ac;
   logic       wr;
   logic       data_e;
   logic       halt;
   logic [2:0] phase;

   modport master (
      input  en, opcode, zero,
      output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
   );

   modport slave (
      output en, opcode, zero,
      input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
   );

endinterface

// File: rtl/cpu_controller_phase_counter.sv
// Three-bit wrapping phase counter; advances when enabled and not held.
module cpu_phase_counter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_en,
   input  logic       i_hold,
   output logic [2:0] o_count
);

   logic [2:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 3'd0;
      end else if (i_en && !i_hold) begin
         r_count <= r_count + 3'd1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer: steps the phase counter and decodes
// phase, opcode and the accumulator-zero flag into datapath control strobes.
module cpu_controller
   import cpu_pkg::*;
#(
   parameter bit HALT_STICKY = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   cpu_controller_if.master  bus
);

   logic [2:0] w_count;
   phase_e     w_phase;
   logic       r_halted;
   logic       w_halted_nxt;
   logic       w_halt_entry;
   logic       w_hold;
   logic       w_aluop;
   strobe_t    w_strb;

   cpu_phase_counter u_phase_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (bus.en),
      .i_hold  (w_hold),
      .o_count (w_count)
   );

   assign w_phase = phase_e'(w_count);
   assign w_aluop = is_aluop(bus.opcode);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_halted <= 1'b0;
      end else begin
         r_halted <= w_halted_nxt;
      end
   end

   // Halt entry also freezes the counter on the same edge, so the phase stays at OP_ADDR.
   always_comb begin
      w_halt_entry = 1'b0;
      if ((HALT_STICKY != 1'b0) && !r_halted && (w_phase == OP_ADDR) &&
          (bus.opcode == OP_HLT) && bus.en) begin
         w_halt_entry = 1'b1;
      end
      w_halted_nxt = r_halted | w_halt_entry;
   end

   assign w_hold = r_halted | w_halt_entry;

   always_comb begin
      w_strb = '0;
      case (w_phase)
         INST_ADDR: begin
            w_strb.sel = 1'b1;
         end
         INST_FETCH: begin
            w_strb.sel = 1'b1;
            w_strb.rd  = 1'b1;
         end
         INST_LOAD, IDLE: begin
            w_strb.sel   = 1'b1;
            w_strb.rd    = 1'b1;
            w_strb.ld_ir = 1'b1;
         end
         OP_ADDR: begin
            w_strb.inc_pc = 1'b1;
            w_strb.halt   = (bus.opcode == OP_HLT);
         end
         OP_FETCH: begin
            w_strb.rd = w_aluop;
         end
         ALU_OP: begin
            w_strb.rd     = w_aluop;
            w_strb.inc_pc = (bus.opcode == OP_SKZ) && bus.zero;
            w_strb.ld_pc  = (bus.opcode == OP_JMP);
            w_strb.data_e = (bus.opcode == OP_STO);
         end
         STORE: begin
            w_strb.rd     = w_aluop;
            w_strb.ld_ac  = w_aluop;
            w_strb.inc_pc = (bus.opcode == OP_JMP);
            w_strb.ld_pc  = (bus.opcode == OP_JMP);
            w_strb.wr     = (bus.opcode == OP_STO);
            w_strb.data_e = (bus.opcode == OP_STO);
         end
         default: begin
            w_strb = '0;
         end
      endcase
      // A halted CPU shows only the halt indication.
      if (r_halted) begin
         w_strb      = '0;
         w_strb.halt = 1'b1;
      end
   end

   assign bus.sel    = w_strb.sel;
   assign bus.rd     = w_strb.rd;
   assign bus.ld_ir  = w_strb.ld_ir;
   assign bus.inc_pc = w_strb.inc_pc;
   assign bus.ld_pc  = w_strb.ld_pc;
   assign bus.ld_ac  = w_strb.ld_ac;
   assign bus.wr     = w_strb.wr;
   assign bus.data_e = w_strb.data_e;
   assign bus.halt   = w_strb.halt;
   assign bus.phase  = w_count;

endmodule
